// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write busy bits, optional writeback
// bypass, and RAW/WAW hazard detection for the decode stage.
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                ctrl_clk,
  input  logic                ctrl_reset,
  input  logic [NRD-1:0]      rd_ren,
  input  logic [NRD*AW-1:0]   rd_raddr,
  output logic [NRD*XLEN-1:0] rd_rdata,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_valid,
  input  logic                iss_wen,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_accept,
  output logic                ctrl_hazard,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_waddr,
  input  logic [XLEN-1:0]     wb_wdata,
  output logic [NREGS-1:0]    busy_vec
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             wb_en;
  logic             iss_set;
  logic             raw;
  logic             waw;
  logic             iss_rd_busy;
  logic [NRD-1:0]   raw_vec;

  // x0 is hard-wired: writes to it never count as a real writeback.
  assign wb_en = wb_valid && (wb_waddr != '0);

  // Read ports: zero-latency, optionally forwarding the writeback in flight.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;

    assign addr = rd_raddr[gi*AW +: AW];
    assign hit  = BYP && wb_en && (wb_waddr == addr);

    assign rd_rdata[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                       hit          ? wb_wdata :
                                                      regs_q[addr];
    assign rd_busy[gi] = hit ? 1'b0 : busy_q[addr];
    assign raw_vec[gi] = rd_ren[gi] && rd_busy[gi];
  end

  // Destination busy as seen this cycle; a forwarded writeback frees it early.
  assign iss_rd_busy = busy_q[iss_rd] && !(BYP && wb_en && (wb_waddr == iss_rd));

  assign raw         = |raw_vec;
  assign waw         = iss_wen && (iss_rd != '0) && iss_rd_busy;
  assign ctrl_hazard = iss_valid && (raw || waw);
  assign iss_accept  = iss_valid && !ctrl_hazard;
  assign iss_set     = iss_accept && iss_wen && (iss_rd != '0);
  assign busy_vec    = busy_q;

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_en) begin
      regs_d[wb_waddr] = wb_wdata;
      busy_d[wb_waddr] = 1'b0;
    end
    // Issue set is applied after the writeback clear so it wins on a collision.
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge ctrl_clk or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives a bypassing and a non-bypassing instance with identical stimulus and
// compares every output against a per-instance behavioural model each cycle.
module tb_regfile_scoreboard;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                ctrl_clk = 1'b0;
  logic                ctrl_reset;
  logic [NRD-1:0]      rd_ren;
  logic [NRD*AW-1:0]   rd_raddr;
  logic                iss_valid;
  logic                iss_wen;
  logic [AW-1:0]       iss_rd;
  logic                wb_valid;
  logic [AW-1:0]       wb_waddr;
  logic [XLEN-1:0]     wb_wdata;

  // Index 1 = BYPASS=1 instance, index 0 = BYPASS=0 instance.
  logic [NRD*XLEN-1:0] o_rdata [2];
  logic [NRD-1:0]      o_rbusy [2];
  logic                o_acc   [2];
  logic                o_haz   [2];
  logic [NREGS-1:0]    o_bv    [2];

  logic [XLEN-1:0]     m_reg  [2][NREGS];
  logic                m_busy [2][NREGS];
  logic                exp_acc [2];

  int n_checks = 0;
  int n_fail   = 0;
  int n_cyc    = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(1)) dut_byp (
    .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset),
    .rd_ren(rd_ren), .rd_raddr(rd_raddr), .rd_rdata(o_rdata[1]), .rd_busy(o_rbusy[1]),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
    .iss_accept(o_acc[1]), .ctrl_hazard(o_haz[1]),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .busy_vec(o_bv[1])
  );

  regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .BYPASS(0)) dut_nobyp (
    .ctrl_clk(ctrl_clk), .ctrl_reset(ctrl_reset),
    .rd_ren(rd_ren), .rd_raddr(rd_raddr), .rd_rdata(o_rdata[0]), .rd_busy(o_rbusy[0]),
    .iss_valid(iss_valid), .iss_wen(iss_wen), .iss_rd(iss_rd),
    .iss_accept(o_acc[0]), .ctrl_hazard(o_haz[0]),
    .wb_valid(wb_valid), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .busy_vec(o_bv[0])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < NREGS; r++) begin
        m_reg[b][r]  = '0;
        m_busy[b][r] = 1'b0;
      end
    end
  endtask

  task automatic idle();
    rd_ren    = '0;
    rd_raddr  = '0;
    iss_valid = 1'b0;
    iss_wen   = 1'b0;
    iss_rd    = '0;
    wb_valid  = 1'b0;
    wb_waddr  = '0;
    wb_wdata  = '0;
  endtask

  task automatic set_reads(input logic [1:0] ren, input int a0, input int a1);
    rd_ren   = ren;
    rd_raddr = {AW'(a1), AW'(a0)};
  endtask

  // Expected outputs derived from the model state plus this cycle's inputs.
  task automatic check_all();
    for (int b = 0; b < 2; b++) begin
      logic [NRD*XLEN-1:0] e_rdata;
      logic [NRD-1:0]      e_busy;
      logic [NREGS-1:0]    e_bv;
      logic                raw, waw, haz, wb_frees_rd;
      raw = 1'b0;
      for (int i = 0; i < NRD; i++) begin
        int  a;
        bit  fwd;
        a   = int'(rd_raddr[i*AW +: AW]);
        fwd = (b == 1) && wb_valid && (int'(wb_waddr) == a) && (a != 0);
        e_rdata[i*XLEN +: XLEN] = (a == 0) ? '0 : (fwd ? wb_wdata : m_reg[b][a]);
        e_busy[i] = fwd ? 1'b0 : m_busy[b][a];
        if (rd_ren[i] && e_busy[i]) raw = 1'b1;
      end
      wb_frees_rd = (b == 1) && wb_valid && (wb_waddr == iss_rd);
      waw = iss_wen && (iss_rd != 0) && m_busy[b][iss_rd] && !wb_frees_rd;
      haz = iss_valid && (raw || waw);
      exp_acc[b] = iss_valid && !haz;
      for (int r = 0; r < NREGS; r++) e_bv[r] = m_busy[b][r];
      check($sformatf("rdata[b%0d]", b), o_rdata[b], e_rdata);
      check($sformatf("rd_busy[b%0d]", b), o_rbusy[b], e_busy);
      check($sformatf("hazard[b%0d]", b), o_haz[b], haz);
      check($sformatf("accept[b%0d]", b), o_acc[b], exp_acc[b]);
      check($sformatf("busy_vec[b%0d]", b), o_bv[b], e_bv);
    end
  endtask

  task automatic update_model();
    for (int b = 0; b < 2; b++) begin
      if (wb_valid && wb_waddr != 0) begin
        m_reg[b][wb_waddr]  = wb_wdata;
        m_busy[b][wb_waddr] = 1'b0;
      end
      if (exp_acc[b] && iss_wen && iss_rd != 0) m_busy[b][iss_rd] = 1'b1;
    end
  endtask

  task automatic probe();
    #1;
    check_all();
  endtask

  task automatic advance(input string tag);
    $display("cyc %0d %s iss=%0b/%0b/%0d wb=%0b/%0d/%h acc=%0b%0b haz=%0b%0b",
             n_cyc, tag, iss_valid, iss_wen, iss_rd, wb_valid, wb_waddr, wb_wdata,
             o_acc[1], o_acc[0], o_haz[1], o_haz[0]);
    @(posedge ctrl_clk);
    if (ctrl_reset) update_model();
    @(negedge ctrl_clk);
    n_cyc++;
  endtask

  task automatic cycle(input string tag);
    probe();
    advance(tag);
  endtask

  task automatic random_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      set_reads(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      iss_valid = ($urandom_range(0, 3) != 0);
      iss_wen   = ($urandom_range(0, 3) != 0);
      iss_rd    = AW'($urandom_range(0, 7));
      wb_valid  = ($urandom_range(0, 1) != 0);
      wb_waddr  = AW'($urandom_range(0, 7));
      wb_wdata  = $urandom;
      cycle("rand");
    end
    idle();
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < NREGS; a++) begin
      set_reads(2'b11, a, NREGS - 1 - a);
      cycle(tag);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", n_cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and full read-out.
    ctrl_reset = 1'b0;
    idle();
    m_reset();
    #3;
    check_all();
    check("reset_bv", o_bv[1], 0);
    @(posedge ctrl_clk);
    @(negedge ctrl_clk);
    ctrl_reset = 1'b1;
    read_all("t1_read");

    // RAW on x5, then cleared by same-cycle writeback on the bypass instance.
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 5;
    cycle("t2_issue5");
    idle();
    iss_valid = 1'b1; set_reads(2'b01, 5, 0);
    probe();
    check("t2_raw_haz", o_haz[1], 1);
    check("t2_raw_acc", o_acc[1], 0);
    advance("t2_raw");
    wb_valid = 1'b1; wb_waddr = 5; wb_wdata = 32'hDEADBEEF;
    probe();
    check("t2_fwd_data", o_rdata[1][31:0], 32'hDEADBEEF);
    check("t2_fwd_haz", o_haz[1], 0);
    check("t2_nofwd_haz", o_haz[0], 1);
    advance("t2_wb5");
    idle();

    // WAW on x7, then accepted alongside the writeback on the bypass instance.
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 7;
    cycle("t3_issue7");
    probe();
    check("t3_waw_haz", o_haz[1], 1);
    advance("t3_waw");
    wb_valid = 1'b1; wb_waddr = 7; wb_wdata = 32'h77;
    probe();
    check("t3_wb_acc", o_acc[1], 1);
    check("t3_nofwd_haz", o_haz[0], 1);
    advance("t3_issue_wb7");
    idle();
    probe();
    check("t3_busy7_byp", o_bv[1][7], 1);
    check("t3_busy7_nobyp", o_bv[0][7], 0);
    advance("t3_after");

    // x0 ignores writes and issues.
    wb_valid = 1'b1; wb_waddr = 0; wb_wdata = 32'h1234;
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 0; set_reads(2'b11, 0, 0);
    probe();
    check("t4_x0_haz", o_haz[1], 0);
    check("t4_x0_data", o_rdata[1], 0);
    advance("t4_x0");
    idle(); set_reads(2'b11, 0, 0);
    probe();
    check("t4_x0_read", o_rdata[0], 0);
    check("t4_x0_busy", o_bv[1][0], 0);
    advance("t4_x0_read");

    // Writeback visibility without forwarding.
    idle();
    iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = 3;
    cycle("t5_issue3");
    idle();
    wb_valid = 1'b1; wb_waddr = 3; wb_wdata = 32'h55; set_reads(2'b10, 0, 3);
    probe();
    check("t5_old_data", o_rdata[0][63:32], 0);
    check("t5_old_busy", o_rbusy[0][1], 1);
    check("t5_fwd_data", o_rdata[1][63:32], 32'h55);
    advance("t5_wb3");
    idle(); set_reads(2'b10, 0, 3);
    probe();
    check("t5_new_data", o_rdata[0][63:32], 32'h55);
    check("t5_new_busy", o_rbusy[0][1], 0);
    advance("t5_read3");
    idle();

    random_cycles(300);

    // Asynchronous reset with busy bits outstanding.
    for (int r = 9; r <= 11; r++) begin
      iss_valid = 1'b1; iss_wen = 1'b1; iss_rd = AW'(r);
      cycle("t6_issue");
    end
    idle(); set_reads(2'b11, 9, 10);
    probe();
    check("t6_pre_busy", o_bv[1][11:9], 3'b111);
    #1;
    ctrl_reset = 1'b0;
    m_reset();
    probe();
    check("t6_rst_bv_byp", o_bv[1], 0);
    check("t6_rst_bv_nobyp", o_bv[0], 0);
    advance("t6_reset");
    ctrl_reset = 1'b1;
    read_all("t6_read");

    random_cycles(150);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
